// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared types and helpers for the LDPC check node datapath
//   cnu_state_t        : check node FSM states (COLLECT, EMIT)
//   CNU_WIDTH_DEFAULT  : default signed message width
//   sat_abs(value, w)  : |value| of a sign-extended w-bit message, clamped to 2^(w-1)-1
package ldpc_pkg;

  localparam int CNU_WIDTH_DEFAULT = 32;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } cnu_state_t;

  // The caller sign-extends its w-bit message to 64 bits; the most negative
  // value has no positive twin, so it is clamped to the largest magnitude.
  function automatic logic [63:0] sat_abs(input logic [63:0] value, input int width);
    logic [63:0] magmax;
    logic [63:0] a;
    magmax = (64'd1 << (width - 1)) - 64'd1;
    a      = value[63] ? (~value + 64'd1) : value;
    return (a > magmax) ? magmax : a;
  endfunction

endpackage

// File: rtl/cnu_min2_tracker.sv
// rtl/cnu_min2_tracker.sv - combinational two-smallest-magnitude update
//   m        in   MW  magnitude of the message being accepted
//   count    in   CW  index of that message within the frame
//   min1     in   MW  current smallest magnitude
//   min2     in   MW  current second smallest magnitude
//   idx      in   CW  index that produced min1
//   min1_nxt out  MW  updated smallest magnitude
//   min2_nxt out  MW  updated second smallest magnitude
//   idx_nxt  out  CW  updated index of min1
module cnu_min2_tracker #(
  parameter int MW = 31,
  parameter int CW = 3
) (
  input  logic [MW-1:0] m,
  input  logic [CW-1:0] count,
  input  logic [MW-1:0] min1,
  input  logic [MW-1:0] min2,
  input  logic [CW-1:0] idx,
  output logic [MW-1:0] min1_nxt,
  output logic [MW-1:0] min2_nxt,
  output logic [CW-1:0] idx_nxt
);

  // Strict compares: an equal magnitude keeps the earlier idx and lands in min2.
  always_comb begin
    min1_nxt = min1;
    min2_nxt = min2;
    idx_nxt  = idx;
    if (m < min1) begin
      min2_nxt = min1;
      min1_nxt = m;
      idx_nxt  = count;
    end else if (m < min2) begin
      min2_nxt = m;
    end
  end

endmodule

// File: rtl/cnu_serial_minsum.sv
// rtl/cnu_serial_minsum.sv - serial min-sum check node unit (one check row per frame)
//   clk     in   1      clock, rising edge
//   reset   in   1      synchronous active-high reset
//   q_data  in   WIDTH  signed variable-to-check message
//   q_valid in   1      q_data valid
//   q_ready out  1      Q accepted this cycle when q_valid is high
//   r_data  out  WIDTH  signed check-to-variable message
//   r_valid out  1      r_data valid
//   r_ready in   1      downstream takes R this cycle
//   r_last  out  1      marks the DEGREE-th R of the frame
//   busy    out  1      frame in progress
//   Optional macro CNU_OFFSET_MINSUM_EN: offset min-sum (subtract OFFSET from R magnitudes).
module cnu_serial_minsum
  import ldpc_pkg::*;
#(
  parameter int DEGREE = 6,
  parameter int WIDTH  = CNU_WIDTH_DEFAULT,
  parameter int OFFSET = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_data,
  input  logic             q_valid,
  output logic             q_ready,
  output logic [WIDTH-1:0] r_data,
  output logic             r_valid,
  input  logic             r_ready,
  output logic             r_last,
  output logic             busy
);

  localparam int CW = (DEGREE > 1) ? $clog2(DEGREE) : 1;
  localparam int MW = WIDTH - 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [MW-1:0] mag_t;

  localparam mag_t MAGMAX = '1;
  localparam cnt_t LAST   = cnt_t'(DEGREE - 1);

`ifdef CNU_OFFSET_MINSUM_EN
  localparam mag_t OFF = mag_t'(OFFSET);
`else
  logic unused_offset;
  assign unused_offset = ^OFFSET;
`endif

  cnu_state_t state;
  cnt_t       count;
  mag_t       min1, min2;
  cnt_t       idx;
  logic       sgn;
  // Sized to the full counter range so any count value indexes in bounds.
  logic [(1<<CW)-1:0] signs;

  logic [63:0] m_wide;
  mag_t        m;
  logic        s;
  logic        q_fire, r_fire;
  mag_t        t_min1, t_min2;
  cnt_t        t_idx;
  cnt_t        nxt;

  logic unused_m_hi;
  assign m_wide      = sat_abs(64'(signed'(q_data)), WIDTH);
  assign m           = m_wide[MW-1:0];
  assign unused_m_hi = ^m_wide[63:MW];
  assign s           = q_data[WIDTH-1];
  assign q_fire      = q_valid & q_ready;
  assign r_fire      = r_valid & r_ready;
  assign nxt         = count + 1'b1;

  cnu_min2_tracker #(
    .MW (MW),
    .CW (CW)
  ) u_tracker (
    .m        (m),
    .count    (count),
    .min1     (min1),
    .min2     (min2),
    .idx      (idx),
    .min1_nxt (t_min1),
    .min2_nxt (t_min2),
    .idx_nxt  (t_idx)
  );

  // R for position k: exclude the holder of min1 by handing it min2 instead.
  function automatic logic [WIDTH-1:0] make_r(input mag_t m1, input mag_t m2,
                                              input cnt_t i, input cnt_t k,
                                              input logic neg);
    mag_t mag;
    mag = (k == i) ? m2 : m1;
`ifdef CNU_OFFSET_MINSUM_EN
    mag = (mag > OFF) ? (mag - OFF) : '0;
`endif
    // Zero is always emitted positive.
    return (neg && (mag != '0)) ? -{1'b0, mag} : {1'b0, mag};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= COLLECT;
      count   <= '0;
      min1    <= MAGMAX;
      min2    <= MAGMAX;
      idx     <= '0;
      sgn     <= 1'b0;
      signs   <= '0;
      q_ready <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          q_ready <= 1'b1;
          if (q_fire) begin
            min1         <= t_min1;
            min2         <= t_min2;
            idx          <= t_idx;
            sgn          <= sgn ^ s;
            signs[count] <= s;
            busy         <= 1'b1;
            if (count == LAST) begin
              // First R is built from the just-updated accumulators so it is
              // valid one cycle after the last Q.
              count   <= '0;
              state   <= EMIT;
              q_ready <= 1'b0;
              r_valid <= 1'b1;
              r_last  <= (LAST == '0);
              r_data  <= make_r(t_min1, t_min2, t_idx, '0, sgn ^ s ^ signs[0]);
            end else begin
              count <= nxt;
            end
          end
        end
        EMIT: begin
          if (r_fire) begin
            if (count == LAST) begin
              state   <= COLLECT;
              count   <= '0;
              min1    <= MAGMAX;
              min2    <= MAGMAX;
              idx     <= '0;
              sgn     <= 1'b0;
              signs   <= '0;
              q_ready <= 1'b1;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_data  <= '0;
              busy    <= 1'b0;
            end else begin
              count  <= nxt;
              r_data <= make_r(min1, min2, idx, nxt, sgn ^ signs[nxt]);
              r_last <= (nxt == LAST);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_cnu_serial_minsum.sv
// tb/tb_cnu_serial_minsum.sv - scoreboard bench for cnu_serial_minsum
module tb_cnu_serial_minsum;

  localparam int     DEG    = 6;
  localparam int     W      = 32;
  localparam int     OFF    = 1;
  localparam longint MAGMAX = 64'h7FFF_FFFF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  q_data = '0;
  logic          q_valid = 1'b0;
  logic          q_ready;
  logic [W-1:0]  r_data;
  logic          r_valid;
  logic          r_ready = 1'b0;
  logic          r_last;
  logic          busy;

  cnu_serial_minsum #(.DEGREE(DEG), .WIDTH(W), .OFFSET(OFF)) dut (
    .clk     (clk),
    .reset   (reset),
    .q_data  (q_data),
    .q_valid (q_valid),
    .q_ready (q_ready),
    .r_data  (r_data),
    .r_valid (r_valid),
    .r_ready (r_ready),
    .r_last  (r_last),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  int            rr_mode = 0;
  int            rix = 0;
  int            stall = 0;
  bit            hold = 0;
  logic [W-1:0]  held_d;
  logic          held_l;

  // Reference: R_i = product of other signs times smallest other magnitude.
  function automatic void model(input int q[DEG], output int r[DEG]);
    for (int i = 0; i < DEG; i++) begin
      longint mn;
      bit     neg;
      mn  = MAGMAX;
      neg = 0;
      for (int j = 0; j < DEG; j++) begin
        if (j != i) begin
          longint a;
          a = q[j];
          if (a < 0) a = -a;
          if (a > MAGMAX) a = MAGMAX;
          if (a < mn) mn = a;
          if (q[j] < 0) neg = ~neg;
        end
      end
`ifdef CNU_OFFSET_MINSUM_EN
      mn = (mn > OFF) ? mn - OFF : 0;
`endif
      r[i] = neg ? int'(-mn) : int'(mn);
    end
  endfunction

  // Monitor: pops the scoreboard on every R handshake, checks hold stability.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hold = 0;
      rix  = 0;
    end else if (r_valid) begin
      if (hold) begin
        tests++;
        if (r_data !== held_d || r_last !== held_l) begin
          fails++;
          $display("FAIL r_hold: got %0d/%b want %0d/%b", $signed(r_data), r_last, $signed(held_d), held_l);
        end
      end
      tests++;
      if (q_ready !== 1'b0) begin
        fails++;
        $display("FAIL q_ready_in_emit: got %b want 0", q_ready);
      end
      if (r_ready) begin
        hold = 0;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL r_unexpected: got %0d with empty scoreboard", $signed(r_data));
        end else begin
          e = sb.pop_front();
          if (r_data !== e.data || r_last !== e.last) begin
            fails++;
            $display("FAIL r_data: got %0d last=%b want %0d last=%b", $signed(r_data), r_last, e.data, e.last);
          end
        end
        rix = r_last ? 0 : rix + 1;
      end else begin
        hold   = 1;
        held_d = r_data;
        held_l = r_last;
      end
    end else begin
      hold = 0;
    end
  end

  // Downstream ready: 0 always on, 1 random, 2 stall R2 for 3 cycles, else off.
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0: r_ready = 1'b1;
      1: r_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (r_valid && rix == 2 && stall < 3) begin
          r_ready = 1'b0;
          stall++;
        end else begin
          r_ready = 1'b1;
        end
      end
      default: r_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input longint got, input longint want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic send_q(input int d);
    int n;
    n       = 0;
    q_data  = d;
    q_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (q_ready) break;
      n++;
      if (n > 300) begin
        tests++;
        fails++;
        $display("FAIL q_timeout: q_ready got 0 want 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    q_valid = 1'b0;
    q_data  = $urandom();
  endtask

  task automatic send_frame(input int q[DEG], input bit gaps);
    int r[DEG];
    exp_t e;
    model(q, r);
    for (int i = 0; i < DEG; i++) begin
      e.data = r[i];
      e.last = (i == DEG - 1);
      sb.push_back(e);
    end
    for (int i = 0; i < DEG; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_q(q[i]);
    end
    @(negedge clk);
    check("first_r_latency", r_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb.size(), 0);
    check("drain_busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  function automatic int rand_msg();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 16) - 8;
      1: return int'($urandom());
      2: begin
        case ($urandom_range(0, 2))
          0: return int'(32'h8000_0000);
          1: return int'(32'h7FFF_FFFF);
          default: return 0;
        endcase
      end
      default: return $urandom_range(0, 2000) - 1000;
    endcase
  endfunction

  initial begin
    int basic[DEG];
    int ties[DEG];
    int satq[DEG];
    int ones[DEG];
    int rq[DEG];
    basic = '{5, -3, 7, -2, 9, 4};
    ties  = '{4, -4, 6, 8, 10, 12};
    satq  = '{int'(32'h8000_0000), 100, 100, 100, 100, 100};
    ones  = '{1, 1, 1, 1, 1, -1};

    rr_mode = 0;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_r_valid", r_valid, 0);
    check("rst_r_last", r_last, 0);
    check("rst_r_data", r_data, 0);
    check("rst_busy", busy, 0);
    check("rst_q_ready", q_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    send_frame(basic, 0);
    drain();
    send_frame(ties, 0);
    drain();
    send_frame(satq, 0);
    drain();
    send_frame(ones, 0);
    drain();

    stall   = 0;
    rr_mode = 2;
    send_frame(basic, 0);
    drain();
    check("stall_cycles", stall, 3);
    rr_mode = 0;

    // Partial frame dropped by reset; only the following frame may appear.
    send_q(basic[0]);
    send_q(basic[1]);
    send_q(basic[2]);
    @(negedge clk);
    check("busy_mid_frame", busy, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_frame(basic, 0);
    drain();

    // Reset while R is pending.
    rr_mode = 3;
    send_frame(basic, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("emit_rst_r_valid", r_valid, 0);
    check("emit_rst_busy", busy, 0);
    rr_mode = 0;
    @(posedge clk);
    #1;
    send_frame(ties, 0);
    drain();

    rr_mode = 1;
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < DEG; i++) rq[i] = rand_msg();
      send_frame(rq, 1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
